mem_access: RTL

Memory-access stage of the five-stage pipeline, directly upstream of the write-back stage. It takes the EXE→MEM bus, performs data-memory loads and stores over a request/acknowledge interface with variable latency, aligns load data, and detects address-alignment exceptions. It produces the 156-bit MEM→WB bus that write-back consumes. Loads and stores are held in the stage until the memory acknowledges; a cancel from write-back suppresses or drains accesses.

---
 rtl/mem_access_pkg.sv | 71 +++++++
 rtl/mem_access_load_store_align.sv | 55 +++++
 rtl/mem_access.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus layouts, access size codes
// and FSM state encoding.
package mem_access_pkg;

    localparam int EXE_MEM_W = 160;
    localparam int MEM_WB_W  = 156;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } ma_state_t;

    // The listed EXE->MEM fields occupy 159 bits; the top bit of the bus is spare.
    typedef struct packed {
        logic        spare;
        logic        load;
        logic        store;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] store_data;
        logic [31:0] exe_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        wen;
        logic [4:0]  wdest;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        brk;
        logic        fetch_error;
        logic        inst_reserved;
        logic        overflow;
        logic [31:0] pc;
    } exe_mem_bus_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        brk;
        logic        fetch_error;
        logic        inst_reserved;
        logic        raddr_error;
        logic        waddr_error;
        logic        overflow;
        logic [31:0] dm_addr;
        logic [31:0] pc;
    } mem_wb_bus_t;

endpackage

// File: rtl/mem_access_load_store_align.sv
// Combinational byte-lane logic: store strobes and replicated write data,
// load byte/halfword extraction with sign/zero extension, alignment check.
module mem_access_load_store_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        align_err
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_byte[addr_lo];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        align_err = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SIZE_HALF: begin
                wstrb     = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
                align_err = addr_lo[0];
            end
            default: begin
                // Any size code other than byte/half is handled as a word access.
                align_err = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory requests, holds the
// instruction until acknowledged, and drains in-flight accesses on cancel.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    input  logic                 cancel,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_pc,
    output logic                 dm_req,
    output logic                 dm_wr,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata
);

    exe_mem_bus_t ex;
    mem_wb_bus_t  wb;
    ma_state_t    state_reg, state_next;
    logic [31:0]  load_data_reg;
    logic [31:0]  aligned_load;
    logic         align_err;
    logic         exc_pending;
    logic         access;
    logic         issue;
    logic         load_capture;
    logic         unused_spare;

    assign ex           = exe_mem_bus_t'(EXE_MEM_bus_r);
    assign unused_spare = ex.spare;

    mem_access_load_store_align u_align (
        .size       (ex.size),
        .sign_ext   (ex.sign_ext),
        .addr_lo    (ex.exe_result[1:0]),
        .store_data (ex.store_data),
        .rdata      (dm_rdata),
        .wstrb      (dm_wstrb),
        .wdata      (dm_wdata),
        .load_data  (aligned_load),
        .align_err  (align_err)
    );

    assign exc_pending = ex.fetch_error | ex.inst_reserved | ex.overflow | ex.syscall | ex.brk;
    assign access      = MEM_valid & (ex.load | ex.store) & ~align_err & ~exc_pending;
    // A store commits at request time, so cancel must gate the request itself.
    assign issue       = access & ~cancel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            load_data_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (load_capture) begin
                load_data_reg <= aligned_load;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        dm_req       = 1'b0;
        MEM_over     = 1'b0;
        load_capture = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                dm_req   = issue;
                MEM_over = MEM_valid & ~issue;
                if (issue) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm_ack) begin
                    // An ack coinciding with cancel has nothing left to drain.
                    state_next   = cancel ? ST_IDLE : ST_DONE;
                    load_capture = ~cancel;
                end else if (cancel) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                MEM_over   = MEM_valid;
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (dm_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dm_wr   = ex.store;
    assign dm_addr = ex.exe_result;

    always_comb begin
        wb               = '0;
        wb.wen           = ex.wen;
        wb.wdest         = ex.wdest;
        wb.mem_result    = ex.load ? load_data_reg : ex.exe_result;
        wb.lo_result     = ex.lo_result;
        wb.hi_write      = ex.hi_write;
        wb.lo_write      = ex.lo_write;
        wb.mfhi          = ex.mfhi;
        wb.mflo          = ex.mflo;
        wb.mtc0          = ex.mtc0;
        wb.mfc0          = ex.mfc0;
        wb.cp0r_addr     = ex.cp0r_addr;
        wb.syscall       = ex.syscall;
        wb.eret          = ex.eret;
        wb.brk           = ex.brk;
        wb.fetch_error   = ex.fetch_error;
        wb.inst_reserved = ex.inst_reserved;
        wb.raddr_error   = ex.load & align_err;
        wb.waddr_error   = ex.store & align_err;
        wb.overflow      = ex.overflow;
        wb.dm_addr       = ex.exe_result;
        wb.pc            = ex.pc;
    end

    assign MEM_WB_bus = wb;
    assign MEM_wdest  = ex.wdest & {5{MEM_valid}};
    assign MEM_pc     = ex.pc;

endmodule
